// File: rtl/gemm_host_ctrl.sv
// AXI4-Lite host initiator: programs the seven GEMM configuration registers, starts the
// accelerator, waits for completion and reads back the cycle counter.
module gemm_host_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [15:0]           cmd_m,
  input  logic [15:0]           cmd_n,
  input  logic [15:0]           cmd_k,
  input  logic [1:0]            cmd_format,
  input  logic                  cmd_accum,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_c,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  acc_start,
  input  logic                  acc_busy,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_cycles,
  output logic                  rsp_error
);

  typedef enum logic [3:0] {
    StIdle, StWr, StBresp, StStart, StWaitBusy, StWaitIdle, StRd, StRdata, StRsp
  } state_t;

  state_t                state;
  logic [15:0]           m_r, n_r, k_r;
  logic [1:0]            fmt_r;
  logic                  accum_r;
  logic [ADDR_WIDTH-1:0] addr_a_r, addr_b_r, addr_c_r;
  logic [2:0]            widx;
  logic                  aw_done, w_done;
  logic                  err;
  logic [31:0]           tcnt;
  logic                  aw_fin, w_fin, timeout;

  function automatic logic [31:0] cfg_word(
    input logic [2:0]            idx,
    input logic [15:0]           m,
    input logic [15:0]           n,
    input logic [15:0]           k,
    input logic [1:0]            fmt,
    input logic                  accum,
    input logic [ADDR_WIDTH-1:0] a,
    input logic [ADDR_WIDTH-1:0] b,
    input logic [ADDR_WIDTH-1:0] c
  );
    logic [31:0] w;
    case (idx)
      3'd0:    w = {16'h0, m};
      3'd1:    w = {16'h0, n};
      3'd2:    w = {16'h0, k};
      3'd3:    w = {29'h0, accum, fmt};
      3'd4:    w = 32'(a);
      3'd5:    w = 32'(b);
      3'd6:    w = 32'(c);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Each write channel may complete in an earlier cycle than the other.
  assign aw_fin  = aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_fin   = w_done  | (m_axi_wvalid  & m_axi_wready);
  assign timeout = (state != StIdle) && (state != StRsp) && (tcnt == 32'(TIMEOUT_CYCLES - 1));

  assign m_axi_wstrb  = 4'hF;
  assign m_axi_bready = 1'b1;
  assign m_axi_rready = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      cmd_ready     <= 1'b1;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      acc_start     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_cycles    <= '0;
      rsp_error     <= 1'b0;
      m_r           <= '0;
      n_r           <= '0;
      k_r           <= '0;
      fmt_r         <= '0;
      accum_r       <= 1'b0;
      addr_a_r      <= '0;
      addr_b_r      <= '0;
      addr_c_r      <= '0;
      widx          <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      err           <= 1'b0;
      tcnt          <= '0;
    end else begin
      tcnt      <= tcnt + 32'd1;
      acc_start <= 1'b0;
      rsp_valid <= 1'b0;
      if (timeout) begin
        // Abort: release the bus and report the failure without a fresh cycle count.
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        err           <= 1'b1;
        rsp_valid     <= 1'b1;
        rsp_error     <= 1'b1;
        tcnt          <= '0;
        state         <= StRsp;
      end else begin
        unique case (state)
          StIdle: begin
            tcnt <= '0;
            if (cmd_valid && cmd_ready) begin
              m_r           <= cmd_m;
              n_r           <= cmd_n;
              k_r           <= cmd_k;
              fmt_r         <= cmd_format;
              accum_r       <= cmd_accum;
              addr_a_r      <= cmd_addr_a;
              addr_b_r      <= cmd_addr_b;
              addr_c_r      <= cmd_addr_c;
              err           <= 1'b0;
              widx          <= '0;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              m_axi_awaddr  <= '0;
              m_axi_wdata   <= cfg_word(3'd0, cmd_m, cmd_n, cmd_k, cmd_format, cmd_accum,
                                        cmd_addr_a, cmd_addr_b, cmd_addr_c);
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              cmd_ready     <= 1'b0;
              state         <= StWr;
            end
          end
          StWr: begin
            if (m_axi_awvalid && m_axi_awready) begin
              m_axi_awvalid <= 1'b0;
              aw_done       <= 1'b1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
              m_axi_wvalid <= 1'b0;
              w_done       <= 1'b1;
            end
            if (aw_fin && w_fin) begin
              tcnt  <= '0;
              state <= StBresp;
            end
          end
          StBresp: begin
            if (m_axi_bvalid) begin
              tcnt <= '0;
              if (m_axi_bresp != 2'b00) err <= 1'b1;
              if (widx == 3'd6) begin
                acc_start <= 1'b1;
                state     <= StStart;
              end else begin
                widx          <= widx + 3'd1;
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
                m_axi_awaddr  <= ADDR_WIDTH'({widx + 3'd1, 2'b00});
                m_axi_wdata   <= cfg_word(widx + 3'd1, m_r, n_r, k_r, fmt_r, accum_r,
                                          addr_a_r, addr_b_r, addr_c_r);
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                state         <= StWr;
              end
            end
          end
          StStart: begin
            tcnt  <= '0;
            state <= StWaitBusy;
          end
          StWaitBusy: begin
            if (acc_busy) begin
              tcnt  <= '0;
              state <= StWaitIdle;
            end
          end
          StWaitIdle: begin
            if (!acc_busy) begin
              tcnt          <= '0;
              m_axi_araddr  <= ADDR_WIDTH'(8'h20);
              m_axi_arvalid <= 1'b1;
              state         <= StRd;
            end
          end
          StRd: begin
            if (m_axi_arready) begin
              tcnt          <= '0;
              m_axi_arvalid <= 1'b0;
              state         <= StRdata;
            end
          end
          StRdata: begin
            if (m_axi_rvalid) begin
              tcnt       <= '0;
              rsp_cycles <= m_axi_rdata;
              rsp_valid  <= 1'b1;
              rsp_error  <= err | (m_axi_rresp != 2'b00);
              err        <= err | (m_axi_rresp != 2'b00);
              state      <= StRsp;
            end
          end
          StRsp: begin
            tcnt      <= '0;
            rsp_error <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gemm_host_ctrl.sv
// Directed bench for gemm_host_ctrl: behavioural AXI4-Lite slave and accelerator model,
// nominal, skewed-slave, error-response, timeout and mid-job reset scenarios.
module tb_gemm_host_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_m, cmd_n, cmd_k;
  logic [1:0]  cmd_format;
  logic        cmd_accum;
  logic [31:0] cmd_addr_a, cmd_addr_b, cmd_addr_c;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bready, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic [31:0] m_axi_rdata = 32'h0;
  logic        acc_start, acc_busy = 1'b0;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_cycles;

  always #5 clk = ~clk;

  gemm_host_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
    .cmd_format(cmd_format), .cmd_accum(cmd_accum),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_c(cmd_addr_c),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .acc_start(acc_start), .acc_busy(acc_busy),
    .rsp_valid(rsp_valid), .rsp_cycles(rsp_cycles), .rsp_error(rsp_error)
  );

  // Slave knobs, written only by the stimulus block.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, err_idx = -1;
  bit          acc_en = 1'b1;
  logic [31:0] rd_val = 32'h0;

  // Slave state and logs, written only by the slave/accelerator models.
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, busy_left = 0;
  bit          aw_got = 0, w_got = 0, ar_busy = 0, r_pend = 0;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, proto_err = 0;
  logic [31:0] aw_log [64];
  logic [31:0] w_log  [64];

  // Responses change on the falling edge so the DUT sees them stable at the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rvalid = 0;
      aw_got = 0; w_got = 0; ar_busy = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      // A valid still high after its handshake edge is a repeated transfer.
      if (aw_got && m_axi_awvalid && !m_axi_bvalid) proto_err++;
      if (w_got && m_axi_wvalid && !m_axi_bvalid) proto_err++;
      if (ar_busy && m_axi_arvalid) proto_err++;
      if (m_axi_bvalid) begin
        m_axi_bvalid = 0; aw_got = 0; w_got = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; n_b++;
      end else if (aw_got && w_got) begin
        if (b_cnt == b_dly) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = (n_b == err_idx) ? 2'b10 : 2'b00;
        end else b_cnt++;
      end
      m_axi_awready = 0;
      m_axi_wready  = 0;
      if (m_axi_awvalid && !aw_got) begin
        if (aw_cnt == aw_dly) begin
          m_axi_awready = 1; aw_got = 1;
          if (n_aw < 64) aw_log[n_aw] = m_axi_awaddr;
          n_aw++;
        end else aw_cnt++;
      end
      if (m_axi_wvalid && !w_got) begin
        if (w_cnt == w_dly) begin
          m_axi_wready = 1; w_got = 1;
          if (n_w < 64) w_log[n_w] = m_axi_wdata;
          n_w++;
        end else w_cnt++;
      end
      m_axi_arready = 0;
      if (m_axi_rvalid) begin
        m_axi_rvalid = 0; ar_busy = 0;
      end else if (r_pend) begin
        m_axi_rvalid = 1; m_axi_rdata = rd_val; m_axi_rresp = 2'b00; r_pend = 0;
      end
      if (m_axi_arvalid && !ar_busy) begin
        if (m_axi_araddr == 32'h20) n_ar++;
        else proto_err++;
        m_axi_arready = 1; ar_busy = 1; r_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (acc_start && acc_en) busy_left = 8;
    if (busy_left > 0) begin
      acc_busy = 1; busy_left--;
    end else acc_busy = 0;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-job results captured by run_job.
  int          b_aw, b_w, b_ar, b_pe, start_cyc, n_start, rsp_at;
  bit          got_rsp;
  logic        rsp_err_s;
  logic [31:0] rsp_cyc_s;

  task automatic run_job(input logic [15:0] m, input logic [15:0] n, input logic [15:0] k,
                         input logic [1:0] f, input logic ac,
                         input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc);
    b_aw = n_aw; b_w = n_w; b_ar = n_ar; b_pe = proto_err;
    start_cyc = -1; n_start = 0; rsp_at = -1; got_rsp = 0;
    cmd_m = m; cmd_n = n; cmd_k = k; cmd_format = f; cmd_accum = ac;
    cmd_addr_a = ba; cmd_addr_b = bb; cmd_addr_c = bc; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    cmd_m = 16'hdead; cmd_n = 16'hbeef; cmd_k = 16'h5a5a; cmd_format = 2'b11; cmd_accum = ~ac;
    cmd_addr_a = 32'hffff_0001; cmd_addr_b = 32'hffff_0002; cmd_addr_c = 32'hffff_0003;
    chk("first_awvalid", m_axi_awvalid, 1);
    chk("first_wvalid", m_axi_wvalid, 1);
    chk("first_awaddr", m_axi_awaddr, 0);
    chk("first_wdata", m_axi_wdata, {16'h0, m});
    chk("busy_cmd_ready", cmd_ready, 0);
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1;
      if (acc_start) begin
        n_start++; start_cyc = i;
      end
      if (rsp_valid) begin
        got_rsp = 1; rsp_at = i; rsp_err_s = rsp_error; rsp_cyc_s = rsp_cycles;
        break;
      end
    end
    chk("rsp_seen", 32'(got_rsp), 1);
    @(posedge clk); #1;
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
  endtask

  task automatic check_writes(input logic [15:0] m, input logic [15:0] n, input logic [15:0] k,
                              input logic [1:0] f, input logic ac,
                              input logic [31:0] ba, input logic [31:0] bb,
                              input logic [31:0] bc);
    logic [31:0] exp_w [7];
    exp_w[0] = {16'h0, m}; exp_w[1] = {16'h0, n}; exp_w[2] = {16'h0, k};
    exp_w[3] = {29'h0, ac, f}; exp_w[4] = ba; exp_w[5] = bb; exp_w[6] = bc;
    chk("aw_count", n_aw - b_aw, 7);
    chk("w_count", n_w - b_w, 7);
    chk("proto_errs", proto_err - b_pe, 0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("awaddr%0d", i), aw_log[b_aw + i], 32'(i * 4));
      chk($sformatf("wdata%0d", i), w_log[b_aw + i], exp_w[i]);
    end
  endtask

  initial begin
    rst = 1; cmd_valid = 0;
    cmd_m = 0; cmd_n = 0; cmd_k = 0; cmd_format = 0; cmd_accum = 0;
    cmd_addr_a = 0; cmd_addr_b = 0; cmd_addr_c = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_cycles", rsp_cycles, 0);
    chk("rst_wstrb", m_axi_wstrb, 4'hF);
    chk("rst_bready", m_axi_bready, 1);
    chk("rst_rready", m_axi_rready, 1);
    rst = 0;
    @(posedge clk); #1;

    // Nominal: zero-latency slave gives 2 cycles per write, start 14 cycles after accept.
    rd_val = 32'h0000_0123;
    run_job(16, 16, 16, 2'd2, 1'b1, 32'h1000, 32'h2000, 32'h3000);
    check_writes(16, 16, 16, 2'd2, 1'b1, 32'h1000, 32'h2000, 32'h3000);
    chk("nom_start_cycle", 32'(start_cyc), 14);
    chk("nom_start_pulses", 32'(n_start), 1);
    chk("nom_ar_count", 32'(n_ar - b_ar), 1);
    chk("nom_rsp_error", rsp_err_s, 0);
    chk("nom_rsp_cycles", rsp_cyc_s, 32'h123);

    // Skewed slave: wready 3 cycles after awready, bvalid 2 cycles later -> 7 cycles per write.
    w_dly = 3; b_dly = 2; rd_val = 32'h0000_0abc;
    run_job(16'd4, 16'd8, 16'd12, 2'd1, 1'b0, 32'h4000, 32'h5000, 32'h6000);
    check_writes(16'd4, 16'd8, 16'd12, 2'd1, 1'b0, 32'h4000, 32'h5000, 32'h6000);
    chk("skew_start_cycle", 32'(start_cyc), 49);
    chk("skew_rsp_error", rsp_err_s, 0);
    chk("skew_rsp_cycles", rsp_cyc_s, 32'habc);
    w_dly = 0; b_dly = 0;

    // Error BRESP on the fourth write (0x0C): sequence completes, error reported.
    err_idx = n_b + 3; rd_val = 32'h0000_0456;
    run_job(16'd2, 16'd3, 16'd5, 2'd0, 1'b1, 32'h10, 32'h20, 32'h30);
    check_writes(16'd2, 16'd3, 16'd5, 2'd0, 1'b1, 32'h10, 32'h20, 32'h30);
    chk("err_rsp_error", rsp_err_s, 1);
    chk("err_rsp_cycles", rsp_cyc_s, 32'h456);
    chk("err_ar_count", 32'(n_ar - b_ar), 1);
    err_idx = -1;

    // Timeout: accelerator never goes busy; abort 50 cycles into WAIT_BUSY.
    acc_en = 0; rd_val = 32'h0000_0999;
    run_job(16'd1, 16'd1, 16'd1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("to_rsp_delay", 32'(rsp_at - start_cyc), 51);
    chk("to_rsp_error", rsp_err_s, 1);
    chk("to_rsp_cycles_held", rsp_cyc_s, 32'h456);
    chk("to_no_ar", 32'(n_ar - b_ar), 0);
    chk("to_arvalid", m_axi_arvalid, 0);
    acc_en = 1;

    // Reset while waiting for a slow BRESP.
    b_dly = 20; b_pe = proto_err;
    cmd_m = 16'd9; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_in_job", cmd_ready, 0);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_awvalid", m_axi_awvalid, 0);
    chk("mid_rst_wvalid", m_axi_wvalid, 0);
    chk("mid_rst_arvalid", m_axi_arvalid, 0);
    chk("mid_rst_acc_start", acc_start, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    rst = 0;
    b_dly = 0;
    begin
      int stray = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (rsp_valid || m_axi_awvalid || acc_start) stray++;
      end
      chk("mid_no_activity", 32'(stray), 0);
    end

    // Clean job after the reset.
    rd_val = 32'h0000_0789;
    run_job(16'd3, 16'd5, 16'd7, 2'd1, 1'b0, 32'h7000, 32'h8000, 32'h9000);
    check_writes(16'd3, 16'd5, 16'd7, 2'd1, 1'b0, 32'h7000, 32'h8000, 32'h9000);
    chk("post_start_cycle", 32'(start_cyc), 14);
    chk("post_rsp_error", rsp_err_s, 0);
    chk("post_rsp_cycles", rsp_cyc_s, 32'h789);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gemm_host_ctrl.md
# gemm_host_ctrl

Host-side AXI4-Lite initiator that programs and runs one GEMM job on `gemm_accelerator`. It sits between a simple command port (from a CPU shim or testbench sequencer) and the accelerator's AXI4-Lite slave plus `start`/`busy` pins. It writes the seven configuration registers, pulses `start`, waits for the job to finish, reads back the cycle counter, and reports status.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, AXI address and base-address width
- `TIMEOUT_CYCLES`, 1000000, max cycles allowed in any wait state before abort

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  job request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_m`, `cmd_n`, `cmd_k`  in  16 each  matrix dimensions
- `cmd_format`  in  2  data_format field
- `cmd_accum`  in  1  accumulate_mode bit
- `cmd_addr_a`, `cmd_addr_b`, `cmd_addr_c`  in  ADDR_WIDTH each  base addresses
- `m_axi_awaddr`  out  ADDR_WIDTH;  `m_axi_awvalid` out 1;  `m_axi_awready` in 1
- `m_axi_wdata` out 32;  `m_axi_wstrb` out 4;  `m_axi_wvalid` out 1;  `m_axi_wready` in 1
- `m_axi_bresp` in 2;  `m_axi_bvalid` in 1;  `m_axi_bready` out 1
- `m_axi_araddr` out ADDR_WIDTH;  `m_axi_arvalid` out 1;  `m_axi_arready` in 1
- `m_axi_rdata` in 32;  `m_axi_rresp` in 2;  `m_axi_rvalid` in 1;  `m_axi_rready` out 1
- `acc_start`  out  1  one-cycle start pulse to accelerator
- `acc_busy`  in  1  accelerator busy
- `rsp_valid`  out  1  one-cycle job-complete pulse
- `rsp_cycles`  out  32  cycle counter read from 0x20
- `rsp_error`  out  1  valid with `rsp_valid`: nonzero BRESP/RRESP or timeout

## Operation
- Reset: all outputs 0 except `cmd_ready`=1, `m_axi_wstrb`=4'hF, `m_axi_bready`=1, `m_axi_rready`=1; state IDLE; error flag cleared.
- IDLE: on `cmd_valid && cmd_ready` latch all cmd fields, widx=0, go WR.
- Write sequence, widx 0..6: 0x00←{16'h0,m}; 0x04←{16'h0,n}; 0x08←{16'h0,k}; 0x0C←{29'h0,accum,format}; 0x10←addr_a; 0x14←addr_b; 0x18←addr_c.
- WR: assert awvalid and wvalid together with address/data. Track AW and W handshakes independently; drop each valid on the cycle after its ready is sampled; when both done go BRESP.
- BRESP: wait `m_axi_bvalid`; bresp≠0 sets error flag (sequence continues). widx<6: widx+1, WR; else START.
- START: `acc_start`=1 for exactly one cycle, go WAIT_BUSY.
- WAIT_BUSY: wait `acc_busy`=1, then WAIT_IDLE. WAIT_IDLE: wait `acc_busy`=0, then RD.
- RD: araddr=0x20, arvalid until arready sampled, then RDATA. RDATA: on `m_axi_rvalid` capture rdata into `rsp_cycles`; rresp≠0 sets error; go RSP.
- RSP: `rsp_valid`=1 one cycle with `rsp_error`, go IDLE.
- Timeout: a 32-bit counter clears on every state change; reaching TIMEOUT_CYCLES in any non-IDLE state sets error, deasserts all AXI valids and `acc_start`, jumps to RSP (`rsp_cycles` holds previous value).
- `cmd_valid` outside IDLE ignored; cmd fields captured only at accept.

## Timing
- accept→first awvalid: 1 cycle. Each write ≥2 cycles (issue + response); slave responding ready+bvalid in the same cycle gives 2 cycles/write.
- AXI rules: valids never drop before ready; addr/data stable while valid; no read and write outstanding together; one transaction outstanding max.
- `acc_start` asserted the cycle after the 7th BRESP handshake.
- `rsp_valid` the cycle after the R handshake.
- `rst` mid-job: next cycle all valids and `acc_start` 0, IDLE, no `rsp_valid`; accelerator is not aborted.
- awready and wready in different cycles: each valid drops independently; BRESP entered only after both.

## Test plan
- Nominal against `gemm_accelerator` (CYCLES_PER_TILE=4): m=n=k=16, bases 0x1000/0x2000/0x3000 → readback 0x00=16, 0x18 base=0x3000; `rsp_valid` with `rsp_error`=0 and `rsp_cycles` nonzero.
- Write-order check: monitor logs 7 AW addresses exactly 0x00,04,08,0C,10,14,18 and wdata 0x0C = {accum,format} (accum=1, format=2 → 0x6).
- Skewed slave: wready 3 cycles after awready, bvalid 2 cycles later → single handshake each, no duplicate writes.
- Error response: BRESP=2'b10 on write 3 → remaining writes still issued, `rsp_error`=1.
- Timeout: `acc_busy` tied 0, TIMEOUT_CYCLES=50 → `rsp_valid` 50 cycles after WAIT_BUSY entry, `rsp_error`=1, no AR issued.
- Reset mid-BRESP wait → next cycle `cmd_ready`=1, all valids 0; new command runs cleanly.
